// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS   = 8;
    localparam logic        UART_IDLE_LEVEL  = 1'b1;
    localparam logic        UART_START_LEVEL = 1'b0;
    localparam logic        UART_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte-stream handshake plus serial line status for the UART transmitter.
interface uart_tx_frame_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS = UART_DATA_BITS
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_out;
    logic                 tx_busy;
    logic                 tx_done;

    // Producer side.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_out,
        input  tx_busy,
        input  tx_done
    );

    // Transmitter side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_out,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/tx_pts_register.sv
// Parallel-in / serial-out shift register; LSB leaves first, vacated bits fill with FILL_LEVEL.
module tx_pts_register
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH       = 9,
    parameter logic        FILL_LEVEL  = UART_STOP_LEVEL,
    parameter logic        RESET_LEVEL = UART_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic             shift_enable,
    input  logic [WIDTH-1:0] parallel_in,
    output logic             serial_out
);

    logic [WIDTH-1:0] shift_q;

    // Load has priority over shift; reset leaves the line at its idle level.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_q <= {WIDTH{RESET_LEVEL}};
        end else if (load) begin
            shift_q <= parallel_in;
        end else if (shift_enable) begin
            shift_q <= {FILL_LEVEL, shift_q[WIDTH-1:1]};
        end
    end

    assign serial_out = shift_q[0];

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per valid/ready handshake, sent as 8N1 on an idle-high line.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
// The whole frame (start, data, [parity]) is loaded into the shift register so tx_out is
// a flop output; ones shifted in behind the payload provide the stop and idle levels.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input logic            clk,
    input logic            n_rst,
    uart_tx_frame_if.slave bus
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_W = DATA_BITS + 2;
`else
    localparam int unsigned FRAME_W = DATA_BITS + 1;
`endif

    tx_state_t          state_q, state_d;
    logic [CNT_W-1:0]   baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic               baud_wrap;
    logic               last_bit;
    logic               load;
    logic               shift_enable;
    logic [FRAME_W-1:0] frame_word;
    logic               serial_out;

    assign baud_wrap = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_idx_q == IDX_W'(DATA_BITS - 1));

`ifdef UART_TX_PARITY_EN
    assign frame_word = {^bus.tx_data, bus.tx_data, UART_START_LEVEL};
`else
    assign frame_word = {bus.tx_data, UART_START_LEVEL};
`endif

    // State, baud counter and data bit index registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

    // Next-state logic; every bit boundary advances the shift register except into IDLE.
    always_comb begin
        state_d      = state_q;
        baud_cnt_d   = baud_cnt_q;
        bit_idx_d    = bit_idx_q;
        load         = 1'b0;
        shift_enable = 1'b0;

        if (state_q != IDLE) begin
            baud_cnt_d = baud_wrap ? '0 : baud_cnt_q + 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.tx_valid) begin
                    load       = 1'b1;
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    shift_enable = 1'b1;
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    shift_enable = 1'b1;
                    if (last_bit) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_wrap) begin
                    shift_enable = 1'b1;
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_wrap) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    tx_pts_register #(
        .WIDTH       (FRAME_W),
        .FILL_LEVEL  (UART_STOP_LEVEL),
        .RESET_LEVEL (UART_IDLE_LEVEL)
    ) u_pts (
        .clk          (clk),
        .n_rst        (n_rst),
        .load         (load),
        .shift_enable (shift_enable),
        .parallel_in  (frame_word),
        .serial_out   (serial_out)
    );

    assign bus.tx_out   = serial_out;
    assign bus.tx_ready = (state_q == IDLE);
    assign bus.tx_busy  = (state_q != IDLE);
    assign bus.tx_done  = (state_q == STOP) && baud_wrap;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with CLKS_PER_BIT=10; honours UART_TX_PARITY_EN.
module tb_uart_tx_frame;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk;
    logic n_rst;

    uart_tx_frame_if #(.DATA_BITS(8)) bus ();

    uart_tx_frame #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks;
    int   errors;
    logic line [0:FRAME+1];
    int   done_cnt;
    int   done_at;
    logic ready1;
    logic busy1;
    logic ready_after;

    // Expected per-bit levels of one frame, bit period i at index i.
    function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    // Number of bit periods in the captured frame that deviate from byte d.
    function automatic int frame_errs(input logic [7:0] d);
        logic [NBITS-1:0] exp_bits;
        int               bad;
        logic             ok;
        exp_bits = frame_bits(d);
        bad = 0;
        for (int b = 0; b < NBITS; b++) begin
            ok = 1'b1;
            for (int c = 0; c < CPB; c++) begin
                if (line[1 + b * CPB + c] !== exp_bits[b]) ok = 1'b0;
            end
            if (!ok) bad++;
        end
        return bad;
    endfunction

    // Called at a negedge with the DUT idle; the byte is accepted at the next posedge.
    task automatic start_byte(input logic [7:0] d);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
    endtask

    // Records cycles 1..FRAME+1 after acceptance; at cycle chg_at inputs change.
    task automatic capture(input int chg_at, input logic [7:0] late_data, input logic late_valid);
        done_cnt = 0;
        done_at  = -1;
        for (int k = 1; k <= FRAME + 1; k++) begin
            if (k == chg_at) begin
                bus.tx_valid = late_valid;
                bus.tx_data  = late_data;
            end
            line[k] = bus.tx_out;
            if (bus.tx_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k == 1) begin
                ready1 = bus.tx_ready;
                busy1  = bus.tx_busy;
            end
            if (k == FRAME + 1) ready_after = bus.tx_ready;
            if (k < FRAME + 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_rst        = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.tx_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_out: got %b want 1", bus.tx_out);
        end
        checks++;
        if (bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_ready: got %b want 1", bus.tx_ready);
        end
        checks++;
        if (bus.tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_busy: got %b want 0", bus.tx_busy);
        end
        checks++;
        if (bus.tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx_done: got %b want 0", bus.tx_done);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.tx_out !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0 ||
                bus.tx_done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_100: got %0d bad idle cycles want 0", bad);
        end
    endtask

    task automatic test_frame_a5();
        int bad;
        start_byte(8'hA5);
        capture(1, 8'h00, 1'b0);
        bad = frame_errs(8'hA5);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL a5_levels: got %0d wrong bit periods want 0", bad);
        end
        checks++;
        if (ready1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL a5_first_cycle: got ready=%b busy=%b want ready=0 busy=1",
                     ready1, busy1);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL a5_done_count: got %0d want 1", done_cnt);
        end
        checks++;
        if (done_at !== FRAME) begin
            errors++;
            $display("FAIL a5_done_cycle: got %0d want %0d", done_at, FRAME);
        end
        checks++;
        if (ready_after !== 1'b1) begin
            errors++;
            $display("FAIL a5_ready_after: got %b want 1", ready_after);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        start_byte(8'h00);
        capture(2, 8'hFF, 1'b1);
        bad = frame_errs(8'h00);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_first_levels: got %0d wrong bit periods want 0", bad);
        end
        checks++;
        if (line[FRAME+1] !== 1'b1 || ready_after !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: got line=%b ready=%b want line=1 ready=1",
                     line[FRAME+1], ready_after);
        end
        @(negedge clk);
        capture(1, 8'h00, 1'b0);
        bad = frame_errs(8'hFF);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL b2b_second_levels: got %0d wrong bit periods want 0", bad);
        end
        checks++;
        if (busy1 !== 1'b1 || done_at !== FRAME) begin
            errors++;
            $display("FAIL b2b_second_timing: got busy1=%b done_at=%0d want busy1=1 done_at=%0d",
                     busy1, done_at, FRAME);
        end
    endtask

    task automatic test_input_change();
        int bad;
        start_byte(8'h3C);
        capture(20, 8'hFF, 1'b0);
        bad = frame_errs(8'h3C);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL chg_levels: got %0d wrong bit periods want 0", bad);
        end
        checks++;
        if (done_cnt !== 1 || done_at !== FRAME) begin
            errors++;
            $display("FAIL chg_done: got count=%0d at=%0d want count=1 at=%0d",
                     done_cnt, done_at, FRAME);
        end
        @(negedge clk);
        checks++;
        if (bus.tx_busy !== 1'b0 || bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL chg_no_reaccept: got busy=%b ready=%b want busy=0 ready=1",
                     bus.tx_busy, bus.tx_ready);
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        int low;
        start_byte(8'h5A);
        bus.tx_valid = 1'b0;
        repeat (34) @(negedge clk);
        // Cycle 35 carries data bit 2 of 0x5A, which is 0.
        checks++;
        if (bus.tx_out !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_pre: got tx_out=%b want 0", bus.tx_out);
        end
        n_rst = 1'b0;
        #1;
        checks++;
        if (bus.tx_out !== 1'b1 || bus.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_immediate: got tx_out=%b ready=%b want 1 1",
                     bus.tx_out, bus.tx_ready);
        end
        checks++;
        if (bus.tx_busy !== 1'b0 || bus.tx_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_status: got busy=%b done=%b want 0 0",
                     bus.tx_busy, bus.tx_done);
        end
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        bad = 0;
        low = 0;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (bus.tx_done !== 1'b0) bad++;
            if (bus.tx_out !== 1'b1) low++;
        end
        checks++;
        if (bad !== 0 || low !== 0) begin
            errors++;
            $display("FAIL rst_mid_quiet: got done_pulses=%0d low_cycles=%0d want 0 0", bad, low);
        end
        start_byte(8'h81);
        capture(1, 8'h00, 1'b0);
        bad = frame_errs(8'h81);
        checks++;
        if (bad !== 0 || done_at !== FRAME) begin
            errors++;
            $display("FAIL rst_mid_resume: got bad=%0d done_at=%0d want 0 %0d",
                     bad, done_at, FRAME);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int bad;
        start_byte(8'h07);
        capture(1, 8'h00, 1'b0);
        bad = frame_errs(8'h07);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL parity_levels: got %0d wrong bit periods want 0", bad);
        end
        checks++;
        if (line[91] !== 1'b1 || line[100] !== 1'b1) begin
            errors++;
            $display("FAIL parity_bit: got %b/%b want 1/1", line[91], line[100]);
        end
        checks++;
        if (done_at !== 110 || ready_after !== 1'b1) begin
            errors++;
            $display("FAIL parity_length: got done_at=%0d ready=%b want 110 1",
                     done_at, ready_after);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_idle();
        test_frame_a5();
        test_back_to_back();
        test_input_change();
        test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

endmodule
